hs_ram_arbiter: RTL and testbench

- Shares the game work-RAM port between the game CPU and the hiscore engine.
- On a hiscore request it holds the CPU at an instruction boundary, then grants the RAM port to the hiscore side. It returns the port to the CPU when the request drops.
- Merges the user/OSD pause request into the same CPU hold output, so the core has one pause input.
- Sits between the hiscore engine, FPGA_NINJAKUN's work RAM, and the pause block.

---
 rtl/hs_arb_pkg.sv | 14 +
 rtl/hs_arb_idle_det.sv | 44 ++++
 rtl/hs_ram_arbiter.sv | 140 ++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_arb_pkg.sv
// rtl/hs_arb_pkg.sv - shared types and counter widths for the hiscore RAM arbiter
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int IDLE_CW = 4;
  localparam int TO_CW   = 12;

endpackage

// File: rtl/hs_arb_idle_det.sv
// rtl/hs_arb_idle_det.sv - counts CPU-enabled cycles with no memory cycle; flags when the bus has settled
module hs_arb_idle_det
  import hs_arb_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic busy,
  output logic settled
);

  localparam logic [IDLE_CW-1:0] SETTLE_C = IDLE_CW'(SETTLE);

  logic [IDLE_CW-1:0] cnt_q;
  logic [IDLE_CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (busy) begin
        cnt_d = '0;
      end else if (cnt_q != SETTLE_C) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Flag on the count being loaded so the grant lands on the same edge the count reaches SETTLE.
  assign settled = !clr && (cnt_d == SETTLE_C);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hs_ram_arbiter.sv
// rtl/hs_ram_arbiter.sv - work-RAM port arbiter between game CPU and hiscore engine, merged CPU pause
// Optional DRAIN timeout with sticky hs_timeout flag when HS_ARB_TIMEOUT_EN is defined.
module hs_ram_arbiter
  import hs_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          cpu_cen,
  input  logic          cpu_mreq,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          pause_req,
  output logic          cpu_hold,
  input  logic          hs_access,
  input  logic [AW-1:0] hs_addr,
  input  logic          hs_we,
  input  logic [DW-1:0] hs_wdata,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_grant,
  output logic          hs_ack,
`ifdef HS_ARB_TIMEOUT_EN
  output logic          hs_timeout,
`endif
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       settled;
  logic       force_grant;
  logic       hold_d;
  logic       grant_d;
  logic       issue;
  logic       pend_q;
  logic       pend_rd_q;

  hs_arb_idle_det #(
    .SETTLE (SETTLE)
  ) u_idle_det (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (state_q != DRAIN),
    .en      (cpu_cen),
    .busy    (cpu_mreq),
    .settled (settled)
  );

`ifdef HS_ARB_TIMEOUT_EN
  localparam logic [TO_CW-1:0] TIMEOUT_C = TO_CW'(TIMEOUT);

  logic [TO_CW-1:0] to_cnt_q;

  assign force_grant = (state_q == DRAIN) && (to_cnt_q == TIMEOUT_C - 1'b1);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q   <= '0;
      hs_timeout <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == DRAIN) ? to_cnt_q + 1'b1 : '0;
      if (force_grant && hs_access && !settled) begin
        hs_timeout <= 1'b1;
      end
    end
  end
`else
  logic [TO_CW-1:0] unused_timeout;

  assign unused_timeout = TO_CW'(TIMEOUT);
  assign force_grant    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs_access) state_d = DRAIN;
      DRAIN: begin
        if (!hs_access) begin
          state_d = RELEASE;
        end else if (settled || force_grant) begin
          state_d = GRANT;
        end
      end
      GRANT:   if (!hs_access) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    hold_d  = pause_req || (state_d != IDLE);
    grant_d = (state_d == GRANT);
    issue   = (state_q == GRANT) && hs_access;
  end

  // Ack and read capture both trail the issuing edge by one, so hs_rdata is valid with hs_ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cpu_hold  <= 1'b0;
      hs_grant  <= 1'b0;
      hs_ack    <= 1'b0;
      hs_rdata  <= '0;
      pend_q    <= 1'b0;
      pend_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_hold  <= hold_d;
      hs_grant  <= grant_d;
      pend_q    <= issue;
      pend_rd_q <= issue && !hs_we;
      hs_ack    <= pend_q;
      if (pend_rd_q) begin
        hs_rdata <= ram_rdata;
      end
    end
  end

  always_comb begin
    if (hs_grant) begin
      ram_addr  = hs_addr;
      ram_we    = hs_we && hs_access;
      ram_wdata = hs_wdata;
    end else begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we && cpu_mreq;
      ram_wdata = cpu_wdata;
    end
  end

  assign cpu_rdata = ram_rdata;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb/tb_hs_ram_arbiter.sv - directed bench for hs_ram_arbiter with a read/ack scoreboard
module tb_hs_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TB_TIMEOUT = 100;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          cpu_cen;
  logic          cpu_mreq;
  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          pause_req;
  logic          cpu_hold;
  logic          hs_access;
  logic [AW-1:0] hs_addr;
  logic          hs_we;
  logic [DW-1:0] hs_wdata;
  logic [DW-1:0] hs_rdata;
  logic          hs_grant;
  logic          hs_ack;
`ifdef HS_ARB_TIMEOUT_EN
  logic          hs_timeout;
`endif
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int   checks = 0;
  int   errors = 0;
  logic ack_pipe = 1'b0;
  logic cur_issue = 1'b0;
  logic exp_rd [$];
  logic [DW-1:0] exp_dat [$];
  logic [DW-1:0] shadow [int];

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  hs_ram_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .SETTLE  (2),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .cpu_cen    (cpu_cen),
    .cpu_mreq   (cpu_mreq),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .pause_req  (pause_req),
    .cpu_hold   (cpu_hold),
    .hs_access  (hs_access),
    .hs_addr    (hs_addr),
    .hs_we      (hs_we),
    .hs_wdata   (hs_wdata),
    .hs_rdata   (hs_rdata),
    .hs_grant   (hs_grant),
    .hs_ack     (hs_ack),
`ifdef HS_ARB_TIMEOUT_EN
    .hs_timeout (hs_timeout),
`endif
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic          rd;
    logic [DW-1:0] d;
    @(posedge clk_sys);
    #1;
    chk("hs_ack", {31'd0, hs_ack}, {31'd0, ack_pipe});
    if (hs_ack && exp_rd.size() > 0) begin
      rd = exp_rd.pop_front();
      d  = exp_dat.pop_front();
      if (rd) chk("hs_rdata", {24'd0, hs_rdata}, {24'd0, d});
    end
    ack_pipe  = cur_issue;
    cur_issue = 1'b0;
  endtask

  task automatic hs_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    hs_access = 1'b1;
    hs_we     = we;
    hs_addr   = a;
    hs_wdata  = d;
    cur_issue = 1'b1;
    exp_rd.push_back(!we);
    exp_dat.push_back(we ? 8'h00 : model_rd(a));
    if (we) shadow[int'(a)] = d;
  endtask

  initial begin
    int  idle;
    logic gr;
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(AW'(i));
    reset_n = 1'b0; cpu_cen = 1'b0; cpu_mreq = 1'b0; cpu_addr = '0; cpu_we = 1'b0;
    cpu_wdata = '0; pause_req = 1'b0; hs_access = 1'b0; hs_addr = '0; hs_we = 1'b0; hs_wdata = '0;

    tick(); tick();
    chk("rst_hold", {31'd0, cpu_hold}, 0);
    chk("rst_grant", {31'd0, hs_grant}, 0);
    chk("rst_rdata", {24'd0, hs_rdata}, 0);
    reset_n = 1'b1;
    tick();

    // Drain: CPU busy for 3 cycles, cen every 4th cycle; grant after two idle cen cycles.
    hs_access = 1'b1; cpu_mreq = 1'b1; cpu_cen = 1'b0;
    tick();
    chk("drain_hold_rise", {31'd0, cpu_hold}, 1);
    chk("drain_no_grant", {31'd0, hs_grant}, 0);
    idle = 0; gr = 1'b0;
    for (int i = 1; i <= 20 && !gr; i++) begin
      cpu_mreq = (i < 3);
      cpu_cen  = (i % 4 == 2);
      if (cpu_cen) idle = cpu_mreq ? 0 : idle + 1;
      gr = (idle >= 2);
      tick();
      chk("drain_grant", {31'd0, hs_grant}, {31'd0, gr});
      chk("drain_hold", {31'd0, cpu_hold}, 1);
    end
    chk("drain_reached", {31'd0, gr}, 1);

    // Granted: CPU write attempt must not reach RAM; read, write, read back.
    cpu_we = 1'b1; cpu_mreq = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'hEE; cpu_cen = 1'b1;
    hs_op(1'b0, 16'h1234, 8'h00);
    #1;
    chk("mux_no_cpu_we", {31'd0, ram_we}, 0);
    chk("mux_hs_addr", {16'd0, ram_addr}, 32'h1234);
    tick();
    hs_op(1'b1, 16'h1234, 8'h5A);
    #1;
    chk("mux_hs_we", {31'd0, ram_we}, 1);
    tick();
    hs_op(1'b0, 16'h1234, 8'h00);
    tick();

    // Release: grant drops next edge, hold one cycle later; re-request in RELEASE is ignored.
    hs_access = 1'b0; hs_we = 1'b0; cpu_we = 1'b0; cpu_mreq = 1'b0;
    tick();
    chk("rel_grant", {31'd0, hs_grant}, 0);
    chk("rel_hold", {31'd0, cpu_hold}, 1);
    chk("rd_5a", {24'd0, hs_rdata}, 32'h5A);
    hs_access = 1'b1;
    tick();
    chk("rel_hold_fall", {31'd0, cpu_hold}, 0);
    cpu_we = 1'b1; cpu_mreq = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h3C;
    tick();
    chk("cpu_wr_lands", {24'd0, mem[16'h0010]}, 32'h3C);
    chk("cpu_wr_blocked", {24'd0, mem[16'h0020]}, {24'd0, init_val(16'h0020)});
    chk("resample_hold", {31'd0, cpu_hold}, 1);
    cpu_we = 1'b0; cpu_mreq = 1'b0; cpu_cen = 1'b0; hs_access = 1'b0;
    tick();
    chk("drain_abort_grant", {31'd0, hs_grant}, 0);
    tick();
    chk("drain_abort_hold", {31'd0, cpu_hold}, 0);

    // Pause held across a full grant cycle.
    pause_req = 1'b1;
    tick();
    chk("pause_hold", {31'd0, cpu_hold}, 1);
    cpu_cen = 1'b1; cpu_mreq = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i >= 3 && i <= 7) hs_op(1'b0, AW'(16'h0040 + i), 8'h00);
      else begin hs_access = (i <= 7); hs_we = 1'b0; end
      tick();
      chk("pause_hold_cont", {31'd0, cpu_hold}, 1);
      chk("pause_grant", {31'd0, hs_grant}, {31'd0, (i >= 2 && i <= 7)});
    end
    pause_req = 1'b0;
    tick();
    chk("pause_fall", {31'd0, cpu_hold}, 0);

    // Asynchronous reset in GRANT.
    hs_access = 1'b1; cpu_cen = 1'b1; cpu_mreq = 1'b0;
    tick(); tick(); tick();
    chk("rg_grant", {31'd0, hs_grant}, 1);
    hs_op(1'b0, 16'h0100, 8'h00);
    tick();
    hs_op(1'b0, 16'h0101, 8'h00);
    cpu_addr = 16'h0077; cpu_we = 1'b0;
    tick();
    chk("rg_ack_before", {31'd0, hs_ack}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rg_async_grant", {31'd0, hs_grant}, 0);
    chk("rg_async_hold", {31'd0, cpu_hold}, 0);
    chk("rg_async_ack", {31'd0, hs_ack}, 0);
    chk("rg_port_cpu", {16'd0, ram_addr}, 32'h0077);
    exp_rd.delete(); exp_dat.delete(); ack_pipe = 1'b0; cur_issue = 1'b0;
    hs_access = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("rg_idle_hold", {31'd0, cpu_hold}, 0);
    chk("rg_idle_grant", {31'd0, hs_grant}, 0);

    // cpu_cen stuck low: DRAIN waits.
    hs_access = 1'b1; cpu_cen = 1'b0; cpu_mreq = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("stuck_no_grant", {31'd0, hs_grant}, 0);
    chk("stuck_hold", {31'd0, cpu_hold}, 1);
    cpu_cen = 1'b1;
    tick();
    chk("stuck_one_idle", {31'd0, hs_grant}, 0);
    tick();
    chk("stuck_grant", {31'd0, hs_grant}, 1);
    hs_access = 1'b0;
    tick(); tick();
    chk("stuck_release", {31'd0, cpu_hold}, 0);

`ifdef HS_ARB_TIMEOUT_EN
    chk("to_clear", {31'd0, hs_timeout}, 0);
    hs_access = 1'b1; cpu_cen = 1'b1; cpu_mreq = 1'b1;
    tick();
    for (int k = 1; k <= TB_TIMEOUT; k++) begin
      tick();
      chk("to_grant", {31'd0, hs_grant}, {31'd0, (k == TB_TIMEOUT)});
    end
    chk("to_sticky", {31'd0, hs_timeout}, 1);
    hs_access = 1'b0;
    tick(); tick();
    chk("to_sticky_hold", {31'd0, hs_timeout}, 1);
`endif

    chk("sb_empty", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
